// File: rtl/fb_pkg.sv
// Shared definitions for the HUB75 framebuffer writer.
// Covers panel geometry, RAM word bit layout, FSM states and the address/word helpers.
package fb_pkg;

  localparam int FB_PANEL_W  = 64;
  localparam int FB_PANEL_H  = 64;
  localparam int FB_HALF_H   = 32;
  localparam int FB_COORD_W  = 6;
  localparam int FB_ROW_W    = 5;
  localparam int FB_ADDR_W   = 12;
  localparam int FB_DATA_W   = 16;

  // Each RAM word holds one top-half pixel and the bottom-half pixel 32 rows below it.
  localparam int BIT_R_TOP = 15;
  localparam int BIT_R_BOT = 14;
  localparam int BIT_G_TOP = 13;
  localparam int BIT_G_BOT = 12;
  localparam int BIT_B_TOP = 11;
  localparam int BIT_B_BOT = 10;

  typedef enum logic [2:0] {
    S_ACCEPT,
    S_RD,
    S_RDWAIT,
    S_WR,
    S_SWAP_WAIT
  } fb_state_t;

  // RAM word address: {bank, row within half, column}.
  function automatic logic [FB_ADDR_W-1:0] fb_addr(
    input logic                  bank,
    input logic [FB_ROW_W-1:0]   row,
    input logic [FB_COORD_W-1:0] col
  );
    return {bank, row, col};
  endfunction

  // A top-half pixel owns the whole word: its bits are set and everything else is cleared.
  function automatic logic [FB_DATA_W-1:0] fb_top_word(input logic [2:0] rgb);
    logic [FB_DATA_W-1:0] w;
    w            = '0;
    w[BIT_R_TOP] = rgb[2];
    w[BIT_G_TOP] = rgb[1];
    w[BIT_B_TOP] = rgb[0];
    return w;
  endfunction

  // A bottom-half pixel replaces only its own bits and keeps the rest of the word.
  function automatic logic [FB_DATA_W-1:0] fb_merge_bot(
    input logic [FB_DATA_W-1:0] word,
    input logic [2:0]           rgb
  );
    logic [FB_DATA_W-1:0] w;
    w            = word;
    w[BIT_R_BOT] = rgb[2];
    w[BIT_G_BOT] = rgb[1];
    w[BIT_B_BOT] = rgb[0];
    return w;
  endfunction

endpackage

// File: rtl/fb_raster_counter.sv
// Raster-order x/y position tracker for the incoming pixel stream.
// A start-of-frame marker forces the current pixel to (0,0); a marker seen mid-frame raises o_resync.
module fb_raster_counter
  import fb_pkg::*;
#(
  parameter int PANEL_W = FB_PANEL_W,
  parameter int PANEL_H = FB_PANEL_H
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_advance,
  input  logic                  i_sof,
  output logic [FB_COORD_W-1:0] o_pix_x,
  output logic [FB_COORD_W-1:0] o_pix_y,
  output logic                  o_frame_wrap,
  output logic                  o_resync
);

  localparam logic [FB_COORD_W-1:0] X_LAST = FB_COORD_W'(PANEL_W - 1);
  localparam logic [FB_COORD_W-1:0] Y_LAST = FB_COORD_W'(PANEL_H - 1);

  logic [FB_COORD_W-1:0] r_x;
  logic [FB_COORD_W-1:0] r_y;
  logic                  w_last_x;
  logic                  w_last_y;

  // Position of the pixel being offered; SOF pins it to the origin.
  assign o_pix_x      = i_sof ? '0 : r_x;
  assign o_pix_y      = i_sof ? '0 : r_y;
  assign w_last_x     = (o_pix_x == X_LAST);
  assign w_last_y     = (o_pix_y == Y_LAST);
  assign o_frame_wrap = i_advance & w_last_x & w_last_y;
  assign o_resync     = i_advance & i_sof & ((r_x != '0) | (r_y != '0));

  // Step to the next raster position after every accepted pixel.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_advance) begin
      if (w_last_x) begin
        r_x <= '0;
        r_y <= w_last_y ? '0 : o_pix_y + 1'b1;
      end else begin
        r_x <= o_pix_x + 1'b1;
        r_y <= o_pix_y;
      end
    end
  end

endmodule

// File: rtl/fb_frame_writer.sv
// Writes a 64x64 1-bit-per-channel pixel stream into the back bank of a double-buffered RAM.
// Top-half pixels are written directly; bottom-half pixels use read-modify-write.
// Banks swap only on the panel's vblank pulse after a frame is complete.
module fb_frame_writer
  import fb_pkg::*;
#(
  parameter int PANEL_W = FB_PANEL_W,
  parameter int PANEL_H = FB_PANEL_H,
  parameter int ADDR_W  = FB_ADDR_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_pix_valid,
  output logic                 o_pix_ready,
  input  logic [2:0]           i_pix_rgb,
  input  logic                 i_pix_sof,
  output logic [ADDR_W-1:0]    o_wr_addr,
  output logic [FB_DATA_W-1:0] o_wr_data,
  output logic                 o_wr_en,
  output logic [ADDR_W-1:0]    o_rd_addr,
  output logic                 o_rd_stb,
  input  logic [FB_DATA_W-1:0] i_rd_data,
  input  logic                 i_vblank,
  output logic                 o_front_bank,
  output logic                 o_swap_pending,
  output logic                 o_frame_err
);

  fb_state_t             r_state;
  fb_state_t             w_state_next;
  logic                  r_pix_ready;
  logic [ADDR_W-1:0]     r_wr_addr;
  logic [ADDR_W-1:0]     w_wr_addr_next;
  logic [FB_DATA_W-1:0]  r_wr_data;
  logic [FB_DATA_W-1:0]  w_wr_data_next;
  logic                  r_wr_en;
  logic                  w_wr_en_next;
  logic [ADDR_W-1:0]     r_rd_addr;
  logic [ADDR_W-1:0]     w_rd_addr_next;
  logic                  r_rd_stb;
  logic                  w_rd_stb_next;
  logic                  r_front_bank;
  logic                  w_front_bank_next;
  logic                  r_swap_pending;
  logic                  w_swap_pending_next;
  logic                  r_frame_err;
  logic                  r_frame_done;
  logic                  w_frame_done_next;
  logic [2:0]            r_rgb;
  logic [2:0]            w_rgb_next;

  logic                  w_accept;
  logic [FB_COORD_W-1:0] w_pix_x;
  logic [FB_COORD_W-1:0] w_pix_y;
  logic                  w_frame_wrap;
  logic                  w_resync;
  logic [ADDR_W-1:0]     w_pix_addr;

  assign w_accept = i_pix_valid & r_pix_ready;

  fb_raster_counter #(
    .PANEL_W(PANEL_W),
    .PANEL_H(PANEL_H)
  ) u_raster (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_advance   (w_accept),
    .i_sof       (i_pix_sof),
    .o_pix_x     (w_pix_x),
    .o_pix_y     (w_pix_y),
    .o_frame_wrap(w_frame_wrap),
    .o_resync    (w_resync)
  );

  // Bottom-half rows share words with top-half rows, so only the low 5 row bits address the RAM.
  assign w_pix_addr = fb_addr(~r_front_bank, w_pix_y[FB_ROW_W-1:0], w_pix_x);

  // State register plus the registered RAM-port and status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_ACCEPT;
      r_pix_ready    <= 1'b0;
      r_wr_addr      <= '0;
      r_wr_data      <= '0;
      r_wr_en        <= 1'b0;
      r_rd_addr      <= '0;
      r_rd_stb       <= 1'b0;
      r_front_bank   <= 1'b0;
      r_swap_pending <= 1'b0;
      r_frame_err    <= 1'b0;
      r_frame_done   <= 1'b0;
      r_rgb          <= '0;
    end else begin
      r_state        <= w_state_next;
      r_pix_ready    <= (w_state_next == S_ACCEPT);
      r_wr_addr      <= w_wr_addr_next;
      r_wr_data      <= w_wr_data_next;
      r_wr_en        <= w_wr_en_next;
      r_rd_addr      <= w_rd_addr_next;
      r_rd_stb       <= w_rd_stb_next;
      r_front_bank   <= w_front_bank_next;
      r_swap_pending <= w_swap_pending_next;
      r_frame_err    <= w_resync;
      r_frame_done   <= w_frame_done_next;
      r_rgb          <= w_rgb_next;
    end
  end

  // Next-state and next-output decode for accept, read-modify-write and bank swap.
  always_comb begin
    w_state_next        = r_state;
    w_wr_addr_next      = r_wr_addr;
    w_wr_data_next      = r_wr_data;
    w_wr_en_next        = 1'b0;
    w_rd_addr_next      = r_rd_addr;
    w_rd_stb_next       = 1'b0;
    w_front_bank_next   = r_front_bank;
    w_swap_pending_next = r_swap_pending;
    w_frame_done_next   = r_frame_done;
    w_rgb_next          = r_rgb;
    case (r_state)
      S_ACCEPT: begin
        if (w_accept) begin
          w_wr_addr_next = w_pix_addr;
          if (!w_pix_y[FB_COORD_W-1]) begin
            w_wr_en_next   = 1'b1;
            w_wr_data_next = fb_top_word(i_pix_rgb);
          end else begin
            // Last pixel of a frame is always bottom-half, so the done flag rides the RMW.
            w_rd_stb_next     = 1'b1;
            w_rd_addr_next    = w_pix_addr;
            w_rgb_next        = i_pix_rgb;
            w_frame_done_next = w_frame_wrap;
            w_state_next      = S_RD;
          end
        end
      end
      S_RD: begin
        w_state_next = S_RDWAIT;
      end
      S_RDWAIT: begin
        // Read data is valid this cycle; merge and register it straight into the write port.
        w_wr_en_next   = 1'b1;
        w_wr_data_next = fb_merge_bot(i_rd_data, r_rgb);
        w_state_next   = S_WR;
      end
      S_WR: begin
        if (r_frame_done) begin
          w_swap_pending_next = 1'b1;
          w_frame_done_next   = 1'b0;
          w_state_next        = S_SWAP_WAIT;
        end else begin
          w_state_next = S_ACCEPT;
        end
      end
      S_SWAP_WAIT: begin
        if (i_vblank) begin
          w_front_bank_next   = ~r_front_bank;
          w_swap_pending_next = 1'b0;
          w_state_next        = S_ACCEPT;
        end
      end
      default: begin
        w_state_next = S_ACCEPT;
      end
    endcase
  end

  assign o_pix_ready    = r_pix_ready;
  assign o_wr_addr      = r_wr_addr;
  assign o_wr_data      = r_wr_data;
  assign o_wr_en        = r_wr_en;
  assign o_rd_addr      = r_rd_addr;
  assign o_rd_stb       = r_rd_stb;
  assign o_front_bank   = r_front_bank;
  assign o_swap_pending = r_swap_pending;
  assign o_frame_err    = r_frame_err;

endmodule

// File: tb/tb_fb_frame_writer.sv
// Directed testbench for fb_frame_writer with a small behavioural RAM on the read/write ports.
module tb_fb_frame_writer;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_pix_valid;
  logic        o_pix_ready;
  logic [2:0]  i_pix_rgb;
  logic        i_pix_sof;
  logic [11:0] o_wr_addr;
  logic [15:0] o_wr_data;
  logic        o_wr_en;
  logic [11:0] o_rd_addr;
  logic        o_rd_stb;
  logic [15:0] i_rd_data;
  logic        i_vblank;
  logic        o_front_bank;
  logic        o_swap_pending;
  logic        o_frame_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] ram [0:4095];

  fb_frame_writer dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_pix_valid   (i_pix_valid),
    .o_pix_ready   (o_pix_ready),
    .i_pix_rgb     (i_pix_rgb),
    .i_pix_sof     (i_pix_sof),
    .o_wr_addr     (o_wr_addr),
    .o_wr_data     (o_wr_data),
    .o_wr_en       (o_wr_en),
    .o_rd_addr     (o_rd_addr),
    .o_rd_stb      (o_rd_stb),
    .i_rd_data     (i_rd_data),
    .i_vblank      (i_vblank),
    .o_front_bank  (o_front_bank),
    .o_swap_pending(o_swap_pending),
    .o_frame_err   (o_frame_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Behavioural RAM: write on wr_en, read data valid the cycle after rd_stb.
  always @(posedge i_clk) begin
    if (o_wr_en) ram[o_wr_addr] <= o_wr_data;
    if (o_rd_stb) i_rd_data <= ram[o_rd_addr];
  end

  // The two RAM strobes must never overlap.
  always @(negedge i_clk) begin
    if (o_wr_en && o_rd_stb) begin
      n_bad++;
      $display("FAIL strobe_overlap: wr_en=%0b rd_stb=%0b required not both 1", o_wr_en, o_rd_stb);
    end
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // Offer one pixel and return at T+1 (one step after the accepting edge).
  task automatic send_pixel(input logic [2:0] rgb, input logic sof);
    int n;
    i_pix_valid = 1'b1;
    i_pix_rgb   = rgb;
    i_pix_sof   = sof;
    n = 0;
    while (!o_pix_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: ready=%0b after %0d cycles, required 1", o_pix_ready, n);
    end
    tick();
    i_pix_valid = 1'b0;
    i_pix_sof   = 1'b0;
  endtask

  task automatic stream_pixels(input int count, input logic [2:0] rgb);
    for (int i = 0; i < count; i++) send_pixel(rgb, 1'b0);
  endtask

  task automatic test_reset;
    i_rst_n = 1'b1;
    #1;
    i_rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({o_pix_ready, o_wr_en, o_rd_stb, o_front_bank, o_swap_pending, o_frame_err} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b required 000000",
               {o_pix_ready, o_wr_en, o_rd_stb, o_front_bank, o_swap_pending, o_frame_err});
    end
    n_cmp++;
    if ({o_wr_addr, o_rd_addr, o_wr_data} !== 40'h0) begin
      n_bad++;
      $display("FAIL reset_buses: wr_addr=%h rd_addr=%h wr_data=%h required 0", o_wr_addr, o_rd_addr, o_wr_data);
    end
    i_rst_n = 1'b1;
    tick();
    n_cmp++;
    if (o_pix_ready !== 1'b1 || o_front_bank !== 1'b0) begin
      n_bad++;
      $display("FAIL release: ready=%0b front=%0b required 1/0", o_pix_ready, o_front_bank);
    end
    $display("reset: released, ready=%0b front=%0b", o_pix_ready, o_front_bank);
  endtask

  task automatic test_top_pixel;
    stream_pixels(197, 3'b000);
    send_pixel(3'b101, 1'b0);
    n_cmp++;
    if (o_wr_en !== 1'b1 || o_wr_addr !== 12'h8C5 || o_wr_data !== 16'h8800) begin
      n_bad++;
      $display("FAIL top_write: en=%0b addr=%h data=%h required 1/8c5/8800", o_wr_en, o_wr_addr, o_wr_data);
    end
    n_cmp++;
    if (o_pix_ready !== 1'b1 || o_rd_stb !== 1'b0) begin
      n_bad++;
      $display("FAIL top_ready: ready=%0b rd_stb=%0b required 1/0", o_pix_ready, o_rd_stb);
    end
    $display("top (5,3): en=%0b addr=%h data=%h", o_wr_en, o_wr_addr, o_wr_data);
  endtask

  task automatic test_bottom_pixel;
    stream_pixels(2047, 3'b000);
    send_pixel(3'b010, 1'b0);
    n_cmp++;
    if (o_rd_stb !== 1'b1 || o_rd_addr !== 12'h8C5 || o_wr_en !== 1'b0 || o_pix_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bot_read: stb=%0b addr=%h wr_en=%0b ready=%0b required 1/8c5/0/0",
               o_rd_stb, o_rd_addr, o_wr_en, o_pix_ready);
    end
    tick();
    n_cmp++;
    if (o_rd_stb !== 1'b0 || o_wr_en !== 1'b0 || o_pix_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bot_wait: stb=%0b wr_en=%0b ready=%0b required 0/0/0", o_rd_stb, o_wr_en, o_pix_ready);
    end
    tick();
    n_cmp++;
    if (o_wr_en !== 1'b1 || o_wr_addr !== 12'h8C5 || o_wr_data !== 16'h9800 || o_pix_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bot_write: en=%0b addr=%h data=%h ready=%0b required 1/8c5/9800/0",
               o_wr_en, o_wr_addr, o_wr_data, o_pix_ready);
    end
    $display("bottom (5,35): en=%0b addr=%h data=%h", o_wr_en, o_wr_addr, o_wr_data);
    tick();
    n_cmp++;
    if (o_pix_ready !== 1'b1 || o_wr_en !== 1'b0) begin
      n_bad++;
      $display("FAIL bot_done: ready=%0b wr_en=%0b required 1/0", o_pix_ready, o_wr_en);
    end
  endtask

  task automatic test_frame_swap;
    stream_pixels(1849, 3'b000);
    i_vblank = 1'b1;
    tick();
    i_vblank = 1'b0;
    n_cmp++;
    if (o_front_bank !== 1'b0) begin
      n_bad++;
      $display("FAIL vblank_ignored: front=%0b required 0", o_front_bank);
    end
    send_pixel(3'b000, 1'b0);
    tick();
    tick();
    n_cmp++;
    if (o_wr_en !== 1'b1 || o_wr_addr !== 12'hFFF) begin
      n_bad++;
      $display("FAIL last_write: en=%0b addr=%h required 1/fff", o_wr_en, o_wr_addr);
    end
    tick();
    tick();
    tick();
    n_cmp++;
    if (o_swap_pending !== 1'b1 || o_pix_ready !== 1'b0 || o_front_bank !== 1'b0) begin
      n_bad++;
      $display("FAIL swap_wait: pending=%0b ready=%0b front=%0b required 1/0/0",
               o_swap_pending, o_pix_ready, o_front_bank);
    end
    i_vblank = 1'b1;
    tick();
    i_vblank = 1'b0;
    n_cmp++;
    if (o_front_bank !== 1'b1 || o_swap_pending !== 1'b0 || o_pix_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL swap: front=%0b pending=%0b ready=%0b required 1/0/1",
               o_front_bank, o_swap_pending, o_pix_ready);
    end
    $display("swap: front=%0b pending=%0b", o_front_bank, o_swap_pending);
    send_pixel(3'b111, 1'b0);
    n_cmp++;
    if (o_wr_en !== 1'b1 || o_wr_addr !== 12'h000 || o_wr_data !== 16'hA800) begin
      n_bad++;
      $display("FAIL new_frame: en=%0b addr=%h data=%h required 1/000/a800", o_wr_en, o_wr_addr, o_wr_data);
    end
  endtask

  task automatic test_rst_mid_rmw;
    stream_pixels(2047, 3'b000);
    send_pixel(3'b100, 1'b0);
    n_cmp++;
    if (o_rd_stb !== 1'b1 || o_rd_addr !== 12'h000) begin
      n_bad++;
      $display("FAIL rmw_read: stb=%0b addr=%h required 1/000", o_rd_stb, o_rd_addr);
    end
    tick();
    i_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o_wr_en !== 1'b0 || o_front_bank !== 1'b0 || o_pix_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rmw_abort: wr_en=%0b front=%0b ready=%0b required 0/0/0", o_wr_en, o_front_bank, o_pix_ready);
    end
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();
    n_cmp++;
    if (o_wr_en !== 1'b0 || o_pix_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rmw_release: wr_en=%0b ready=%0b required 0/1", o_wr_en, o_pix_ready);
    end
    tick();
    n_cmp++;
    if (o_wr_en !== 1'b0) begin
      n_bad++;
      $display("FAIL rmw_no_write: wr_en=%0b required 0", o_wr_en);
    end
    send_pixel(3'b001, 1'b0);
    n_cmp++;
    if (o_wr_en !== 1'b1 || o_wr_addr !== 12'h800 || o_wr_data !== 16'h0800) begin
      n_bad++;
      $display("FAIL rmw_restart: en=%0b addr=%h data=%h required 1/800/0800", o_wr_en, o_wr_addr, o_wr_data);
    end
    $display("reset mid-rmw: next write addr=%h", o_wr_addr);
  endtask

  task automatic test_sof_resync;
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();
    send_pixel(3'b000, 1'b1);
    n_cmp++;
    if (o_frame_err !== 1'b0 || o_wr_addr !== 12'h800) begin
      n_bad++;
      $display("FAIL sof_origin: err=%0b addr=%h required 0/800", o_frame_err, o_wr_addr);
    end
    stream_pixels(99, 3'b000);
    send_pixel(3'b110, 1'b1);
    n_cmp++;
    if (o_frame_err !== 1'b1 || o_wr_en !== 1'b1 || o_wr_addr !== 12'h800 || o_wr_data !== 16'hA000) begin
      n_bad++;
      $display("FAIL sof_resync: err=%0b en=%0b addr=%h data=%h required 1/1/800/a000",
               o_frame_err, o_wr_en, o_wr_addr, o_wr_data);
    end
    tick();
    n_cmp++;
    if (o_frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL sof_pulse: err=%0b required 0", o_frame_err);
    end
    send_pixel(3'b000, 1'b0);
    n_cmp++;
    if (o_wr_addr !== 12'h801) begin
      n_bad++;
      $display("FAIL sof_next: addr=%h required 801", o_wr_addr);
    end
    $display("sof resync: following pixel addr=%h", o_wr_addr);
  endtask

  task automatic test_back_to_back;
    logic [11:0] exp_addr;
    i_pix_valid = 1'b1;
    i_pix_rgb   = 3'b011;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_addr = 12'h802 + 12'(i);
      n_cmp++;
      if (o_wr_en !== 1'b1 || o_wr_addr !== exp_addr || o_wr_data !== 16'h2800 || o_pix_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_%0d: en=%0b addr=%h data=%h ready=%0b required 1/%h/2800/1",
                 i, o_wr_en, o_wr_addr, o_wr_data, o_pix_ready, exp_addr);
      end
      $display("back-to-back %0d: addr=%h", i, o_wr_addr);
    end
    i_pix_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 16'h0000;
    i_rst_n     = 1'b1;
    i_pix_valid = 1'b0;
    i_pix_rgb   = 3'b000;
    i_pix_sof   = 1'b0;
    i_vblank    = 1'b0;
    test_reset();
    test_top_pixel();
    test_bottom_pixel();
    test_frame_swap();
    test_rst_mid_rmw();
    test_sof_resync();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
